// File: rtl/retire_trace_checker.sv
// Retire-stream comparator: buffers the DUT and golden commit traces in two
// independent FIFOs, compares heads pairwise under a field mask and latches
// diagnostic state with a sticky error on the first divergence.
module retire_trace_checker #(
  parameter int unsigned              DATA_WIDTH = 69,
  parameter int unsigned              DEPTH      = 16,
  parameter logic [DATA_WIDTH-1:0]    CMP_MASK   = {DATA_WIDTH{1'b1}},
  parameter int unsigned              TIMEOUT    = 4096,
  parameter int unsigned              CNT_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dut_valid,
  input  logic [DATA_WIDTH-1:0]     dut_data,
  input  logic                      ref_valid,
  input  logic [DATA_WIDTH-1:0]     ref_data,
  input  logic                      flush,
  output logic                      err,
  output logic [2:0]                err_code,
  output logic [DATA_WIDTH-1:0]     err_dut_data,
  output logic [DATA_WIDTH-1:0]     err_ref_data,
  output logic [CNT_WIDTH-1:0]      match_cnt,
  output logic [$clog2(DEPTH):0]    dut_level,
  output logic [$clog2(DEPTH):0]    ref_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  // One extra bit so the counter can step past TIMEOUT-1 on the erroring edge.
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam logic [LW-1:0] FullLvl = LW'(DEPTH);
  localparam logic [TW-1:0] ToLast  = TW'(TIMEOUT - 1);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] dut_mem [DEPTH];
  logic [DATA_WIDTH-1:0] ref_mem [DEPTH];
  logic [AW-1:0]         dut_wr_q, dut_wr_d, dut_rd_q, dut_rd_d;
  logic [AW-1:0]         ref_wr_q, ref_wr_d, ref_rd_q, ref_rd_d;
  logic [LW-1:0]         dut_level_q, dut_level_d, ref_level_q, ref_level_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic [CNT_WIDTH-1:0]  match_cnt_q, match_cnt_d;
  logic                  err_q, err_d;
  logic [2:0]            err_code_q, err_code_d;
  logic [DATA_WIDTH-1:0] err_dut_q, err_dut_d, err_ref_q, err_ref_d;

  logic                  run, dut_empty, ref_empty, dut_full, ref_full;
  logic                  heads_eq, pop, mismatch, dut_ovf, ref_ovf, one_side, to_hit;
  logic                  any_err, dut_push, ref_push;
  logic [DATA_WIDTH-1:0] dut_head, ref_head;

  // Datapath conditions for this cycle.
  always_comb begin
    run       = (state_q == StRun);
    dut_empty = (dut_level_q == '0);
    ref_empty = (ref_level_q == '0);
    dut_full  = (dut_level_q == FullLvl);
    ref_full  = (ref_level_q == FullLvl);
    dut_head  = dut_mem[dut_rd_q];
    ref_head  = ref_mem[ref_rd_q];
    heads_eq  = ((dut_head ^ ref_head) & CMP_MASK) == '0;
    pop       = run && !dut_empty && !ref_empty && heads_eq;
    mismatch  = run && !dut_empty && !ref_empty && !heads_eq;
    dut_ovf   = run && dut_valid && dut_full && !pop;
    ref_ovf   = run && ref_valid && ref_full && !pop;
    one_side  = dut_empty ^ ref_empty;
    to_hit    = run && one_side && (to_cnt_q == ToLast);
    any_err   = mismatch || dut_ovf || ref_ovf || to_hit;
    // Overflowing records are dropped; pushes into non-full FIFOs still land.
    dut_push  = run && dut_valid && (!dut_full || pop);
    ref_push  = run && ref_valid && (!ref_full || pop);
  end

  // Next-state: FSM, FIFO pointers/levels, counters and error capture.
  always_comb begin
    state_d     = state_q;
    dut_wr_d    = dut_wr_q;
    dut_rd_d    = dut_rd_q;
    ref_wr_d    = ref_wr_q;
    ref_rd_d    = ref_rd_q;
    dut_level_d = dut_level_q;
    ref_level_d = ref_level_q;
    to_cnt_d    = to_cnt_q;
    match_cnt_d = match_cnt_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    err_dut_d   = err_dut_q;
    err_ref_d   = err_ref_q;

    if (dut_push) dut_wr_d = dut_wr_q + AW'(1);
    if (ref_push) ref_wr_d = ref_wr_q + AW'(1);
    if (pop) begin
      dut_rd_d    = dut_rd_q + AW'(1);
      ref_rd_d    = ref_rd_q + AW'(1);
      match_cnt_d = match_cnt_q + CNT_WIDTH'(1);
    end

    unique case ({dut_push, pop})
      2'b10:   dut_level_d = dut_level_q + LW'(1);
      2'b01:   dut_level_d = dut_level_q - LW'(1);
      default: dut_level_d = dut_level_q;
    endcase
    unique case ({ref_push, pop})
      2'b10:   ref_level_d = ref_level_q + LW'(1);
      2'b01:   ref_level_d = ref_level_q - LW'(1);
      default: ref_level_d = ref_level_q;
    endcase

    if (run) begin
      if (pop || !one_side) to_cnt_d = '0;
      else                  to_cnt_d = to_cnt_q + TW'(1);
    end

    unique case (state_q)
      StRun: begin
        if (any_err) begin
          state_d   = StHalt;
          err_d     = 1'b1;
          err_dut_d = dut_empty ? '0 : dut_head;
          err_ref_d = ref_empty ? '0 : ref_head;
          if (mismatch)     err_code_d = 3'd1;
          else if (dut_ovf) err_code_d = 3'd2;
          else if (ref_ovf) err_code_d = 3'd3;
          else              err_code_d = 3'd4;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  // Control/status registers; flush behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q     <= StRun;
      dut_wr_q    <= '0;
      dut_rd_q    <= '0;
      ref_wr_q    <= '0;
      ref_rd_q    <= '0;
      dut_level_q <= '0;
      ref_level_q <= '0;
      to_cnt_q    <= '0;
      match_cnt_q <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      err_dut_q   <= '0;
      err_ref_q   <= '0;
    end else begin
      state_q     <= state_d;
      dut_wr_q    <= dut_wr_d;
      dut_rd_q    <= dut_rd_d;
      ref_wr_q    <= ref_wr_d;
      ref_rd_q    <= ref_rd_d;
      dut_level_q <= dut_level_d;
      ref_level_q <= ref_level_d;
      to_cnt_q    <= to_cnt_d;
      match_cnt_q <= match_cnt_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_dut_q   <= err_dut_d;
      err_ref_q   <= err_ref_d;
    end
  end

  // FIFO storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (dut_push) dut_mem[dut_wr_q] <= dut_data;
      if (ref_push) ref_mem[ref_wr_q] <= ref_data;
    end
  end

  assign err          = err_q;
  assign err_code     = err_code_q;
  assign err_dut_data = err_dut_q;
  assign err_ref_data = err_ref_q;
  assign match_cnt    = match_cnt_q;
  assign dut_level    = dut_level_q;
  assign ref_level    = ref_level_q;

endmodule

// File: tb/tb_retire_trace_checker.sv
// Directed bench: three checker instances share one stimulus stream; the
// default one, one with compare bit 0 masked off and one with a short timeout.
module tb_retire_trace_checker;

  localparam int unsigned DW = 69;
  localparam logic [DW-1:0] MaskNoB0 = ~(DW'(1));

  logic          clk, rst, flush;
  logic          dut_valid, ref_valid;
  logic [DW-1:0] dut_data, ref_data;

  logic f_err, m_err, s_err;
  logic [2:0] f_code, m_code, s_code;
  logic [DW-1:0] f_edut, f_eref, m_edut, m_eref, s_edut, s_eref;
  logic [31:0] f_match, m_match, s_match;
  logic [4:0] f_dlvl, f_rlvl, m_dlvl, m_rlvl, s_dlvl, s_rlvl;

  int n_checks = 0;
  int n_errors = 0;

  retire_trace_checker u_full (
    .clk(clk), .rst(rst), .dut_valid(dut_valid), .dut_data(dut_data),
    .ref_valid(ref_valid), .ref_data(ref_data), .flush(flush),
    .err(f_err), .err_code(f_code), .err_dut_data(f_edut), .err_ref_data(f_eref),
    .match_cnt(f_match), .dut_level(f_dlvl), .ref_level(f_rlvl)
  );

  retire_trace_checker #(.CMP_MASK(MaskNoB0)) u_nob0 (
    .clk(clk), .rst(rst), .dut_valid(dut_valid), .dut_data(dut_data),
    .ref_valid(ref_valid), .ref_data(ref_data), .flush(flush),
    .err(m_err), .err_code(m_code), .err_dut_data(m_edut), .err_ref_data(m_eref),
    .match_cnt(m_match), .dut_level(m_dlvl), .ref_level(m_rlvl)
  );

  retire_trace_checker #(.TIMEOUT(8)) u_short (
    .clk(clk), .rst(rst), .dut_valid(dut_valid), .dut_data(dut_data),
    .ref_valid(ref_valid), .ref_data(ref_data), .flush(flush),
    .err(s_err), .err_code(s_code), .err_dut_data(s_edut), .err_ref_data(s_eref),
    .match_cnt(s_match), .dut_level(s_dlvl), .ref_level(s_rlvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given strobes; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic dv, input logic [DW-1:0] dd,
                     input logic rv, input logic [DW-1:0] rd);
    dut_valid = dv;
    dut_data  = dd;
    ref_valid = rv;
    ref_data  = rd;
    @(posedge clk);
    #1;
    dut_valid = 1'b0;
    ref_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    dut_valid = 1'b0; ref_valid = 1'b0; dut_data = '0; ref_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_err", f_err, 0);
    check("rst_code", f_code, 0);
    check("rst_match", f_match, 0);
    check("rst_dlvl", f_dlvl, 0);
    check("rst_rlvl", f_rlvl, 0);
    check("rst_edut", f_edut, 0);

    // 1: 100 lock-step identical records
    for (int i = 1; i <= 100; i++) cyc(1'b1, DW'(i), 1'b1, DW'(i));
    check("t1_match_inflight", f_match, 99);
    cyc(1'b0, '0, 1'b0, '0);
    check("t1_match", f_match, 100);
    check("t1_err", f_err, 0);
    check("t1_dlvl", f_dlvl, 0);
    check("t1_rlvl", f_rlvl, 0);

    // 2a: DUT fills to DEPTH, then ref catches up
    do_flush();
    check("t2_flush_match", f_match, 0);
    for (int i = 1; i <= 16; i++) cyc(1'b1, DW'(i), 1'b0, '0);
    check("t2_dlvl_peak", f_dlvl, 16);
    check("t2_err_full", f_err, 0);
    for (int i = 1; i <= 16; i++) cyc(1'b0, '0, 1'b1, DW'(i));
    cyc(1'b0, '0, 1'b0, '0);
    check("t2_match", f_match, 16);
    check("t2_err", f_err, 0);
    check("t2_dlvl_end", f_dlvl, 0);

    // 2b: 17th DUT record overflows
    do_flush();
    for (int i = 1; i <= 16; i++) cyc(1'b1, DW'(i), 1'b0, '0);
    cyc(1'b1, DW'(17), 1'b0, '0);
    check("t2_ovf_err", f_err, 1);
    check("t2_ovf_code", f_code, 2);
    check("t2_ovf_edut", f_edut, 1);
    check("t2_ovf_eref", f_eref, 0);
    check("t2_ovf_dlvl", f_dlvl, 16);
    // HALT ignores pushes and freezes status
    cyc(1'b0, '0, 1'b1, DW'(1));
    cyc(1'b0, '0, 1'b0, '0);
    check("t2_halt_rlvl", f_rlvl, 0);
    check("t2_halt_match", f_match, 0);
    check("t2_halt_code", f_code, 2);

    // 3: 5th record differs in bit 0
    do_flush();
    for (int i = 1; i <= 4; i++) cyc(1'b1, DW'(i), 1'b1, DW'(i));
    cyc(1'b1, DW'(5), 1'b1, DW'(4));
    cyc(1'b0, '0, 1'b0, '0);
    cyc(1'b0, '0, 1'b0, '0);
    check("t3_full_err", f_err, 1);
    check("t3_full_code", f_code, 1);
    check("t3_full_match", f_match, 4);
    check("t3_full_edut", f_edut, 5);
    check("t3_full_eref", f_eref, 4);
    check("t3_nob0_err", m_err, 0);
    check("t3_nob0_match", m_match, 5);
    check("t3_nob0_code", m_code, 0);

    // 4: timeout with TIMEOUT=8
    do_flush();
    cyc(1'b1, DW'(42), 1'b0, '0);
    repeat (7) cyc(1'b0, '0, 1'b0, '0);
    check("t4_err_early", s_err, 0);
    cyc(1'b0, '0, 1'b0, '0);
    check("t4_err", s_err, 1);
    check("t4_code", s_code, 4);
    check("t4_edut", s_edut, 42);
    check("t4_eref", s_eref, 0);
    check("t4_full_no_to", f_err, 0);

    // 5: push into a full FIFO on the same edge as a pop
    do_flush();
    for (int i = 1; i <= 16; i++) cyc(1'b1, DW'(i), 1'b0, '0);
    cyc(1'b0, '0, 1'b1, DW'(1));
    cyc(1'b1, DW'(17), 1'b1, DW'(2));
    check("t5_err", f_err, 0);
    check("t5_dlvl", f_dlvl, 16);
    check("t5_rlvl", f_rlvl, 1);
    check("t5_match", f_match, 1);
    cyc(1'b0, '0, 1'b0, '0);
    check("t5_match2", f_match, 2);
    check("t5_dlvl2", f_dlvl, 15);

    // 6: mismatch, flush, recovery
    do_flush();
    cyc(1'b1, DW'(5), 1'b1, DW'(6));
    cyc(1'b0, '0, 1'b0, '0);
    check("t6_err_set", f_err, 1);
    do_flush();
    check("t6_err_clr", f_err, 0);
    check("t6_code_clr", f_code, 0);
    check("t6_edut_clr", f_edut, 0);
    for (int i = 7; i <= 9; i++) cyc(1'b1, DW'(i), 1'b1, DW'(i));
    cyc(1'b0, '0, 1'b0, '0);
    check("t6_match", f_match, 3);
    check("t6_dlvl", f_dlvl, 0);
    check("t6_rlvl", f_rlvl, 0);
    check("t6_err", f_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
